// File: rtl/mem_dev_bridge.sv
// mem_dev_bridge
//   Memory-stage bridge between the M-stage pipeline register and NDEV
//   memory-mapped peripherals. Decodes the data address, flags DM hits,
//   raises AdEL/AdES on illegal accesses and runs legal device accesses as
//   request/acknowledge transactions while stalling the pipeline. A watchdog
//   turns a missing acknowledge into a bus-error exception.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no device transaction; decode/exception evaluation of M stage
//   WAIT  | dev_req held, waiting for the selected device to acknowledge
//   DONE  | one-cycle completion strobe, bus error reported here if any
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   req, we, size, addr   M-stage access descriptor (size 1 word/2 half/3 byte)
//   wdata                 forwarded store data
//   kill                  blocks the start of a new access this cycle
//   stall                 freeze F/D/E/M
//   rdata, done           device read data, valid with the done strobe
//   dm_hit                address lies in data memory (combinational)
//   exc_code              0 none, 4 AdEL, 5 AdES, 7 bus error
//   dev_req/sel/addr/wdata/we   device bus request side
//   dev_ack, dev_rdata    per-device acknowledge and read data
module mem_dev_bridge #(
    parameter int          NDEV       = 2,
    parameter logic [31:0] DEV_BASE   = 32'h7f00,
    parameter logic [31:0] DEV_STRIDE = 32'h10,
    parameter int          DEV_SIZE   = 12,
    parameter int          RO_OFF     = 8,
    parameter logic [31:0] DM_TOP     = 32'h2fff,
    parameter int          TIMEOUT    = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    input  logic                 we,
    input  logic [1:0]           size,
    input  logic [31:0]          addr,
    input  logic [31:0]          wdata,
    input  logic                 kill,
    output logic                 stall,
    output logic [31:0]          rdata,
    output logic                 done,
    output logic                 dm_hit,
    output logic [4:0]           exc_code,
    output logic                 dev_req,
    output logic [NDEV-1:0]      dev_sel,
    output logic [29:0]          dev_addr,
    output logic [31:0]          dev_wdata,
    output logic                 dev_we,
    input  logic [NDEV-1:0]      dev_ack,
    input  logic [NDEV*32-1:0]   dev_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [1:0] SZ_WORD = 2'd1;
    localparam logic [1:0] SZ_HALF = 2'd2;
    localparam logic [1:0] SZ_BYTE = 2'd3;

    state_e            state_q, state_d;
    logic [NDEV-1:0]   sel_q, sel_d;
    logic [29:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              berr_q, berr_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [NDEV-1:0]   hit;
    logic [NDEV-1:0]   hit_sel;
    logic              hit_found;
    logic              ro_hit;
    logic [31:0]       off;
    logic              dev_hit;
    logic              access;
    logic              misalign;
    logic              narrow_dev;
    logic              unmapped;
    logic              exc_any;
    logic              start;
    logic              ack_sel;
    logic [31:0]       rdata_sel;
    logic [7:0]        cnt_inc;

    // Window decode. The offset is taken relative to each base with unsigned
    // wrap, so an address below a base yields a huge offset and misses.
    always_comb begin
        hit       = '0;
        hit_sel   = '0;
        hit_found = 1'b0;
        ro_hit    = 1'b0;
        off       = '0;
        for (int i = 0; i < NDEV; i++) begin
            off = addr - (DEV_BASE + DEV_STRIDE * 32'(i));
            if (off < 32'(DEV_SIZE)) begin
                hit[i] = 1'b1;
                if (off >= 32'(RO_OFF) && off < 32'(RO_OFF + 4)) begin
                    ro_hit = 1'b1;
                end
            end
        end
        // Windows should not overlap; if they do, the lowest index wins so
        // the latched select stays one-hot.
        for (int i = 0; i < NDEV; i++) begin
            if (hit[i] && !hit_found) begin
                hit_sel[i] = 1'b1;
                hit_found  = 1'b1;
            end
        end
    end

    assign dev_hit = |hit;
    assign dm_hit  = (addr <= DM_TOP);

    always_comb begin
        access     = req && (size != 2'd0);
        misalign   = ((size == SZ_WORD) && (addr[1:0] != 2'b00)) ||
                     ((size == SZ_HALF) && addr[0]);
        narrow_dev = dev_hit && ((size == SZ_HALF) || (size == SZ_BYTE));
        unmapped   = !dm_hit && !dev_hit;
        exc_any    = access && (misalign || narrow_dev || unmapped || (we && ro_hit));
        start      = access && dev_hit && !exc_any && !kill;
    end

    // Selected device response; acks from unselected devices never reach here.
    always_comb begin
        ack_sel   = |(dev_ack & sel_q);
        rdata_sel = '0;
        for (int i = 0; i < NDEV; i++) begin
            if (sel_q[i]) begin
                rdata_sel = rdata_sel | dev_rdata[i*32 +: 32];
            end
        end
    end

    assign cnt_inc = (cnt_q == 8'hff) ? cnt_q : cnt_q + 8'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            berr_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            berr_q  <= berr_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        berr_d  = berr_q;
        rdata_d = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT;
                    sel_d   = hit_sel;
                    addr_d  = addr[31:2];
                    wdata_d = wdata;
                    we_d    = we;
                    cnt_d   = '0;
                    berr_d  = 1'b0;
                end
            end
            S_WAIT: begin
                // An ack in the timeout cycle wins over the bus error.
                if (ack_sel) begin
                    rdata_d = rdata_sel;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == 8'(TIMEOUT)) begin
                        berr_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        stall    = 1'b0;
        done     = 1'b0;
        dev_req  = 1'b0;
        exc_code = 5'd0;
        unique case (state_q)
            S_IDLE: begin
                stall = start;
                if (exc_any) begin
                    exc_code = we ? 5'd5 : 5'd4;
                end
            end
            S_WAIT: begin
                stall   = 1'b1;
                dev_req = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
                if (berr_q) begin
                    exc_code = 5'd7;
                end
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

    assign rdata     = rdata_q;
    assign dev_sel   = sel_q;
    assign dev_addr  = addr_q;
    assign dev_wdata = wdata_q;
    assign dev_we    = we_q && (state_q == S_WAIT);

endmodule

// File: tb/tb_mem_dev_bridge.sv
// tb_mem_dev_bridge
//   Directed bench for mem_dev_bridge. Completion responses (done/rdata/
//   exc_code) are pushed into a scoreboard queue when a transaction is
//   issued and popped by a monitor on every done strobe. Cycle-level and
//   combinational responses are checked inline.
module tb_mem_dev_bridge;

    localparam int NDEV = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic                req;
    logic                we;
    logic [1:0]          size;
    logic [31:0]         addr;
    logic [31:0]         wdata;
    logic                kill;
    logic                stall;
    logic [31:0]         rdata;
    logic                done;
    logic                dm_hit;
    logic [4:0]          exc_code;
    logic                dev_req;
    logic [NDEV-1:0]     dev_sel;
    logic [29:0]         dev_addr;
    logic [31:0]         dev_wdata;
    logic                dev_we;
    logic [NDEV-1:0]     dev_ack;
    logic [NDEV*32-1:0]  dev_rdata;

    always #5 clk = ~clk;

    mem_dev_bridge #(
        .NDEV       (NDEV),
        .DEV_BASE   (32'h7f00),
        .DEV_STRIDE (32'h10),
        .DEV_SIZE   (12),
        .RO_OFF     (8),
        .DM_TOP     (32'h2fff),
        .TIMEOUT    (15)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .size      (size),
        .addr      (addr),
        .wdata     (wdata),
        .kill      (kill),
        .stall     (stall),
        .rdata     (rdata),
        .done      (done),
        .dm_hit    (dm_hit),
        .exc_code  (exc_code),
        .dev_req   (dev_req),
        .dev_sel   (dev_sel),
        .dev_addr  (dev_addr),
        .dev_wdata (dev_wdata),
        .dev_we    (dev_we),
        .dev_ack   (dev_ack),
        .dev_rdata (dev_rdata)
    );

    typedef struct {
        logic [31:0] rdata;
        logic [4:0]  exc;
        bit          chk_rdata;
        string       name;
    } exp_t;

    typedef struct packed {
        logic        w;
        logic [1:0]  s;
        logic [31:0] a;
        logic [4:0]  x;
        logic        dm;
    } vec_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req_v);
        n_checks++;
        if (act !== req_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, req_v);
        end
    endtask

    task automatic push(input string name, input logic [31:0] r, input logic [4:0] x, input bit c);
        exp_t t;
        t.rdata     = r;
        t.exc       = x;
        t.chk_rdata = c;
        t.name      = name;
        sb.push_back(t);
    endtask

    task automatic drive(input logic r, input logic w, input logic [1:0] s,
                         input logic [31:0] a, input logic [31:0] d);
        req   = r;
        we    = w;
        size  = s;
        addr  = a;
        wdata = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Scoreboard monitor: every done strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no completion pending");
            end else begin
                e = sb.pop_front();
                chk({e.name, "_exc"}, 64'(exc_code), 64'(e.exc));
                if (e.chk_rdata) chk({e.name, "_rdata"}, 64'(rdata), 64'(e.rdata));
            end
        end
    end

    vec_t vecs [7];
    int   req_cycles;

    initial begin
        reset     = 1'b1;
        kill      = 1'b0;
        dev_ack   = '0;
        dev_rdata = '0;
        drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        vecs = '{
            '{1'b1, 2'd1, 32'h0000_7f08, 5'd5, 1'b0},
            '{1'b0, 2'd3, 32'h0000_7f01, 5'd4, 1'b0},
            '{1'b0, 2'd1, 32'h0000_2ffc, 5'd0, 1'b1},
            '{1'b0, 2'd1, 32'h0000_3000, 5'd4, 1'b0},
            '{1'b1, 2'd2, 32'h0000_0002, 5'd0, 1'b1},
            '{1'b0, 2'd1, 32'h0000_7f02, 5'd4, 1'b0},
            '{1'b1, 2'd3, 32'h0000_7f15, 5'd5, 1'b0}
        };

        #2;
        chk("rst_stall",     64'(stall),     64'd0);
        chk("rst_done",      64'(done),      64'd0);
        chk("rst_dev_req",   64'(dev_req),   64'd0);
        chk("rst_dev_we",    64'(dev_we),    64'd0);
        chk("rst_dev_sel",   64'(dev_sel),   64'd0);
        chk("rst_rdata",     64'(rdata),     64'd0);
        chk("rst_dev_addr",  64'(dev_addr),  64'd0);
        chk("rst_dev_wdata", 64'(dev_wdata), 64'd0);
        chk("rst_exc",       64'(exc_code),  64'd0);
        smp();
        reset = 1'b0;

        // Word load from device 1; device 0 acks (ignored) at C1, device 1 at C2.
        step();
        drive(1'b1, 1'b0, 2'd1, 32'h7f14, 32'h0);
        dev_rdata = {32'hdeadbeef, 32'h11111111};
        push("ld_7f14", 32'hdeadbeef, 5'd0, 1'b1);
        smp();
        chk("ld_c0_stall",   64'(stall),   64'd1);
        chk("ld_c0_dev_req", 64'(dev_req), 64'd0);
        step();
        dev_ack = 2'b01;
        smp();
        chk("ld_c1_dev_req",  64'(dev_req),  64'd1);
        chk("ld_c1_dev_sel",  64'(dev_sel),  64'h2);
        chk("ld_c1_dev_addr", 64'(dev_addr), 64'h1fc5);
        chk("ld_c1_stall",    64'(stall),    64'd1);
        chk("ld_c1_dev_we",   64'(dev_we),   64'd0);
        step();
        dev_ack = 2'b10;
        smp();
        chk("ld_c2_stall", 64'(stall), 64'd1);
        chk("ld_c2_done",  64'(done),  64'd0);
        step();
        dev_ack = 2'b00;
        smp();
        chk("ld_c3_done",  64'(done),  64'd1);
        chk("ld_c3_stall", 64'(stall), 64'd0);
        step();
        drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        smp();
        chk("ld_c4_done",    64'(done),    64'd0);
        chk("ld_c4_dev_req", 64'(dev_req), 64'd0);

        // Exception and DM decode table.
        foreach (vecs[i]) begin
            step();
            drive(1'b1, vecs[i].w, vecs[i].s, vecs[i].a, 32'h5a5a5a5a);
            smp();
            chk($sformatf("vec%0d_exc", i),     64'(exc_code), 64'(vecs[i].x));
            chk($sformatf("vec%0d_dm_hit", i),  64'(dm_hit),   64'(vecs[i].dm));
            chk($sformatf("vec%0d_stall", i),   64'(stall),    64'd0);
            chk($sformatf("vec%0d_dev_req", i), 64'(dev_req),  64'd0);
        end
        step();
        drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        smp();
        chk("vec_after_dev_req", 64'(dev_req), 64'd0);

        // Store to device 0 with no ack: watchdog bus error.
        step();
        drive(1'b1, 1'b1, 2'd1, 32'h7f00, 32'hcafef00d);
        push("st_timeout", 32'h0, 5'd7, 1'b0);
        smp();
        chk("to_c0_stall", 64'(stall), 64'd1);
        req_cycles = 0;
        for (int k = 1; k <= 15; k++) begin
            step();
            smp();
            if (dev_req) req_cycles++;
            if (k == 1) begin
                chk("to_c1_dev_sel",   64'(dev_sel),   64'h1);
                chk("to_c1_dev_we",    64'(dev_we),    64'd1);
                chk("to_c1_dev_wdata", 64'(dev_wdata), 64'hcafef00d);
                chk("to_c1_dev_addr",  64'(dev_addr),  64'h1fc0);
            end
        end
        chk("to_req_cycles", 64'(req_cycles), 64'd15);
        step();
        smp();
        chk("to_c16_done",    64'(done),    64'd1);
        chk("to_c16_dev_req", 64'(dev_req), 64'd0);
        chk("to_c16_stall",   64'(stall),   64'd0);
        step();
        drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        smp();
        chk("to_c17_done", 64'(done), 64'd0);

        // Kill blocks a start; kill during WAIT/DONE is ignored.
        step();
        drive(1'b1, 1'b0, 2'd1, 32'h7f10, 32'h0);
        kill = 1'b1;
        smp();
        chk("kill_start_stall", 64'(stall), 64'd0);
        step();
        kill = 1'b0;
        dev_rdata = {32'h12345678, 32'h0};
        push("ld_kill_wait", 32'h12345678, 5'd0, 1'b1);
        smp();
        chk("kill_no_dev_req", 64'(dev_req), 64'd0);
        chk("kill_c0_stall",   64'(stall),   64'd1);
        step();
        kill = 1'b1;
        smp();
        chk("kill_c1_dev_req", 64'(dev_req), 64'd1);
        step();
        dev_ack = 2'b10;
        smp();
        chk("kill_c2_dev_req", 64'(dev_req), 64'd1);
        step();
        dev_ack = 2'b00;
        smp();
        chk("kill_c3_done", 64'(done), 64'd1);
        step();
        kill = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);

        // Reset pulsed at C3 of a pending access, then a clean restart.
        step();
        drive(1'b1, 1'b0, 2'd1, 32'h7f04, 32'h0);
        step();
        step();
        smp();
        chk("rstw_c2_dev_req", 64'(dev_req), 64'd1);
        step();
        reset = 1'b1;
        drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
        #1;
        chk("rstw_dev_req", 64'(dev_req), 64'd0);
        chk("rstw_stall",   64'(stall),   64'd0);
        chk("rstw_done",    64'(done),    64'd0);
        smp();
        reset = 1'b0;

        step();
        drive(1'b1, 1'b0, 2'd1, 32'h7f18, 32'h0);
        dev_rdata = {32'haaaa5555, 32'h0};
        push("ld_after_rst", 32'haaaa5555, 5'd0, 1'b1);
        smp();
        chk("rr_c0_stall", 64'(stall), 64'd1);
        step();
        dev_ack = 2'b10;
        smp();
        chk("rr_c1_dev_req", 64'(dev_req), 64'd1);
        chk("rr_c1_dev_sel", 64'(dev_sel), 64'h2);
        step();
        dev_ack = 2'b00;
        smp();
        chk("rr_c2_done", 64'(done), 64'd1);

        // Back-to-back access in the cycle after DONE.
        step();
        drive(1'b1, 1'b0, 2'd1, 32'h7f04, 32'h0);
        dev_rdata = {32'h0, 32'h0badf00d};
        push("ld_b2b", 32'h0badf00d, 5'd0, 1'b1);
        smp();
        chk("b2b_c0_stall", 64'(stall), 64'd1);
        step();
        dev_ack = 2'b01;
        smp();
        chk("b2b_c1_dev_sel", 64'(dev_sel), 64'h1);
        step();
        dev_ack = 2'b00;
        smp();
        chk("b2b_c2_done", 64'(done), 64'd1);
        step();
        drive(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);

        repeat (3) step();
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_dev_bridge.md
# mem_dev_bridge

Parametrised memory-stage bridge between the M-stage pipeline register and up to `NDEV` memory-mapped peripherals. It decodes the data address, checks alignment and access-type legality, and raises `AdEL`/`AdES` exceptions when the access is illegal. Legal device accesses run as multi-cycle request/acknowledge transactions, and the pipeline is stalled until each one completes. A watchdog converts a missing acknowledge into a bus-error exception. Data-memory hits are flagged to the DM and left untouched; the bridge handles them in zero cycles.

## Interface
Parameters:
- `NDEV`, 2: number of device windows, 1..8.
- `DEV_BASE`, 32'h7f00: base address of device 0.
- `DEV_STRIDE`, 32'h10: address distance between consecutive device windows.
- `DEV_SIZE`, 12: bytes decoded per window, starting at its base.
- `RO_OFF`, 8: offset of the read-only word in each window; a store there is `AdES`.
- `DM_TOP`, 32'h2fff: last data-memory byte; DM occupies 0..`DM_TOP`.
- `TIMEOUT`, 15: maximum WAIT cycles before bus error, 1..255.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset. One clock domain; reset is asynchronous and active-high.
- `req` in 1: the M stage holds a load or store.
- `we` in 1: 1 = store, 0 = load.
- `size` in 2: 1 = word, 2 = half, 3 = byte, 0 = no access.
- `addr` in 32: byte address.
- `wdata` in 32: store data, already forwarded.
- `kill` in 1: interrupt or exception taken this cycle; suppresses the start of a new access.
- `stall` out 1: freeze F/D/E/M.
- `rdata` out 32: device read data, valid while `done` is high.
- `done` out 1: single-cycle completion strobe.
- `dm_hit` out 1: address lies in DM. Combinational.
- `exc_code` out 5: 0 none, 4 `AdEL`, 5 `AdES`, 7 bus error.
- `dev_req` out 1: transaction request.
- `dev_sel` out `NDEV`: one-hot selected device.
- `dev_addr` out 30: word address, `addr[31:2]`.
- `dev_wdata` out 32: store data.
- `dev_we` out 1: write enable.
- `dev_ack` in `NDEV`: per-device acknowledge.
- `dev_rdata` in `NDEV`*32: device i occupies bits [32i+31:32i].

## Operation
- Decode, combinational:
  - `hit[i]` = `addr` in [`DEV_BASE`+i*`DEV_STRIDE`, same + `DEV_SIZE`-1].
  - `dm_hit` = `addr` <= `DM_TOP`.
  - `dev_hit` = OR of `hit`.
- Exceptions, combinational, evaluated in IDLE when `req` is high:
  - Conditions: word access with `addr[1:0]`≠0; half access with `addr[0]`≠0; half or byte access to a device; address neither DM nor device; store to `RO_OFF`..`RO_OFF`+3 of any window.
  - Any of these on a load gives 4. On a store it gives 5.
  - An excepting access never starts a transaction and never stalls.
- FSM states are IDLE, WAIT and DONE.
  - IDLE → WAIT: `req` & `dev_hit` & no exception & !`kill`. Latch sel, `addr`, `wdata` and `we`. Clear the watchdog counter.
  - WAIT: `dev_req`=1 and outputs are held stable. On `dev_ack[sel]`, latch `dev_rdata[sel]` and go to DONE. Otherwise increment the counter. When counter = `TIMEOUT`, go to DONE with a bus-error flag.
  - DONE: `done`=1 and `stall`=0. `exc_code`=7 if the bus-error flag is set, else 0 (bus error on a store as well). Always go to IDLE on the next cycle.
- `stall` = (IDLE & start condition) | WAIT.
- `kill` during WAIT or DONE is ignored. A bus transaction is never aborted.
- `dev_ack` from an unselected device is ignored. An ack in the same cycle as the timeout is treated as ack, not as bus error.
- DM accesses: `dm_hit` only. The bridge does not stall and stays in IDLE.

## Timing
- Reset values:
  - state IDLE.
  - `stall`, `done`, `dev_req`, `dev_we` = 0.
  - `dev_sel`, `rdata`, counter = 0.
  - `dev_addr` and `dev_wdata` = 0.
  - `exc_code` = 0 outside IDLE/DONE evaluation.
- Reset mid-WAIT returns to IDLE immediately and drops `dev_req` asynchronously.
- Latency: the start cycle is C0. `dev_req` rises at C1. An ack at cycle Ck (k≥1) gives DONE at Ck+1, so the minimum is 3 cycles.
- Timeout: with no ack, DONE with code 7 comes at C1+`TIMEOUT`. For `TIMEOUT`=15 that is cycle C16.
- The counter is 8-bit and saturates. It cannot wrap because `TIMEOUT`≤255.
- A back-to-back access can start in the cycle after DONE.

## Test plan
- Word load at 32'h7f14, `NDEV`=2, device 1 acks at C2 with 32'hdeadbeef:
  - `dev_sel`=2'b10 and `dev_addr`=30'h1fc5.
  - `stall` high for C0..C2.
  - `done` high at C3 with `rdata`=32'hdeadbeef and `exc_code`=0.
- Store to 32'h7f08: `exc_code`=5, no `dev_req`, `stall`=0. Byte load at 32'h7f01: `exc_code`=4.
- Word load at 32'h2ffc: `dm_hit`=1, `stall`=0. Word load at 32'h3000: `exc_code`=4. Half store at 32'h0002: no exception.
- Store to 32'h7f00 with no ack, `TIMEOUT`=15:
  - `dev_req` high C1..C15.
  - `done` at C16 with `exc_code`=7, then IDLE.
- `kill`=1 with a legal device load: no transaction starts. `kill` asserted during WAIT: the transaction completes normally.
- `reset` pulsed at C3 of a pending access: `dev_req`=0 and `stall`=0 immediately, and the next request starts cleanly.
